// File: rtl/dcache_assoc_pkg.sv
// Shared bus types, size/len/burst encodings and cache FSM states for dcache_assoc.
// Defining UNCACHED_BYPASS_EN adds the StUncached state.
package dcache_assoc_pkg;

   typedef logic [2:0] msize_t;
   typedef logic [3:0] mlen_t;
   typedef logic [1:0] axi_burst_t;

   localparam msize_t     MSIZE1          = 3'd0;
   localparam msize_t     MSIZE2          = 3'd1;
   localparam msize_t     MSIZE4          = 3'd2;
   localparam mlen_t      MLEN1           = 4'd0;
   localparam mlen_t      MLEN16          = 4'd15;
   localparam axi_burst_t AXI_BURST_FIXED = 2'd0;
   localparam axi_burst_t AXI_BURST_INCR  = 2'd1;

   typedef struct packed {
      logic        valid;
      logic [31:0] addr;
      msize_t      size;
      logic [3:0]  strobe;
      logic [31:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [31:0] data;
   } dbus_resp_t;

   typedef struct packed {
      logic        valid;
      logic        is_write;
      msize_t      size;
      logic [31:0] addr;
      logic [3:0]  strobe;
      logic [31:0] data;
      mlen_t       len;
      axi_burst_t  burst;
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [31:0] data;
   } cbus_resp_t;

   typedef enum logic [1:0] {
      StIdle,
      StWriteback,
      StFetch
`ifdef UNCACHED_BYPASS_EN
      , StUncached
`endif
   } state_e;

   // cbus len field encodes beats-1
   function automatic mlen_t mlen_of(input int unsigned words);
      return mlen_t'(words - 1);
   endfunction

endpackage

// File: rtl/dcache_way_ram.sv
// One cache way: per-set data words, tag, valid and dirty bits.
// Data words are never reset; only valid/dirty are cleared by reset_.
module dcache_way_ram
   import dcache_assoc_pkg::*;
#(
   parameter int unsigned SETS       = 4,
   parameter int unsigned LINE_WORDS = 16,
   parameter int unsigned IDX_W      = 2,
   parameter int unsigned WORD_W     = 4,
   parameter int unsigned TAG_W      = 24
) (
   input  logic                             clk,
   input  logic                             reset_,
   input  logic [IDX_W-1:0]                 i_index,
   input  logic [WORD_W-1:0]                i_word,
   input  logic                             i_we,
   input  logic [3:0]                       i_strobe,
   input  logic [31:0]                      i_wdata,
   input  logic                             i_set_dirty,
   input  logic                             i_clr_dirty,
   input  logic                             i_fill,
   input  logic [TAG_W-1:0]                 i_tag,
   output logic [31:0]                      o_word,
   output logic [TAG_W-1:0]                 o_tag,
   output logic                             o_valid,
   output logic                             o_dirty,
   output logic [SETS*LINE_WORDS*32-1:0]    o_flat
);

   logic [31:0]      r_data  [SETS][LINE_WORDS];
   logic [TAG_W-1:0] r_tag   [SETS];
   logic             r_valid [SETS];
   logic             r_dirty [SETS];

   always_ff @(posedge clk) begin
      if (i_we) begin
         for (int b = 0; b < 4; b++) begin
            if (i_strobe[b]) r_data[i_index][i_word][8*b +: 8] <= i_wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_) begin
         for (int s = 0; s < SETS; s++) begin
            r_valid[s] <= 1'b0;
            r_dirty[s] <= 1'b0;
         end
      end else if (i_fill) begin
         r_valid[i_index] <= 1'b1;
         r_tag[i_index]   <= i_tag;
         r_dirty[i_index] <= 1'b0;
      end else if (i_clr_dirty) begin
         r_dirty[i_index] <= 1'b0;
      end else if (i_set_dirty) begin
         r_dirty[i_index] <= 1'b1;
      end
   end

   assign o_word  = r_data[i_index][i_word];
   assign o_tag   = r_tag[i_index];
   assign o_valid = r_valid[i_index];
   assign o_dirty = r_dirty[i_index];

   always_comb begin
      o_flat = '0;
      for (int s = 0; s < SETS; s++) begin
         for (int w = 0; w < LINE_WORDS; w++) begin
            o_flat[(s*LINE_WORDS+w)*32 +: 32] = r_data[s][w];
         end
      end
   end

endmodule

// File: rtl/dcache_assoc.sv
// Set-associative write-back/write-allocate data cache between dbus and cbus.
// Define UNCACHED_BYPASS_EN to route addr[31:29]==3'b101 around the cache.
module dcache_assoc
   import dcache_assoc_pkg::*;
#(
   parameter int unsigned WAYS       = 2,
   parameter int unsigned SETS       = 4,
   parameter int unsigned LINE_WORDS = 16
) (
   input  logic       clk,
   input  logic       reset_,
   input  dbus_req_t  dreq,
   output dbus_resp_t dresp,
   output cbus_req_t  creq,
   input  cbus_resp_t cresp
);

   localparam int unsigned OFF_W    = $clog2(LINE_WORDS) + 2;
   localparam int unsigned IDX_BITS = $clog2(SETS);
   localparam int unsigned IDX_W    = (IDX_BITS > 0) ? IDX_BITS : 1;
   localparam int unsigned WORD_W   = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
   localparam int unsigned W_W      = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int unsigned TAG_W    = 32 - OFF_W - IDX_BITS;
   localparam mlen_t       LINE_LEN = mlen_of(LINE_WORDS);

   state_e            r_state;
   logic [WORD_W-1:0] r_beat;
   logic [W_W-1:0]    r_victim;
   logic [W_W-1:0]    r_rr [SETS];

   logic [IDX_W-1:0]  w_index;
   logic [WORD_W-1:0] w_req_word, w_word_sel;
   logic [TAG_W-1:0]  w_req_tag;
   logic [31:0]       w_req_base, w_vic_base;
   logic [W_W-1:0]    w_rr_cur, w_hit_way;
   logic              w_hit, w_hit_ok, w_write, w_bypass;
   logic [3:0]        w_strobe;
   logic [31:0]       w_wdata;

   logic [31:0]       w_rd_word [WAYS];
   logic [TAG_W-1:0]  w_tag     [WAYS];
   logic [WAYS-1:0]   w_valid, w_dirty, w_we, w_set_dirty, w_clr_dirty, w_fill;
   logic [SETS*LINE_WORDS*32-1:0] w_flat [WAYS];

   // Flattened view of every data word, way-major, for simulator inspection.
   logic [31:0] mem [WAYS*SETS*LINE_WORDS];
   logic        w_unused;

   assign w_index    = IDX_W'((dreq.addr >> OFF_W) & 32'(SETS - 1));
   assign w_req_word = WORD_W'((dreq.addr >> 2) & 32'(LINE_WORDS - 1));
   assign w_req_tag  = dreq.addr[31 -: TAG_W];
   assign w_req_base = {dreq.addr[31:OFF_W], {OFF_W{1'b0}}};
   assign w_vic_base = (32'(w_tag[r_victim]) << (32 - TAG_W)) | (32'(w_index) << OFF_W);
   assign w_rr_cur   = r_rr[w_index];
   assign w_word_sel = (r_state == StIdle) ? w_req_word : r_beat;
   assign w_write    = |dreq.strobe;
   assign w_strobe   = (r_state == StIdle) ? dreq.strobe : 4'hF;
   assign w_wdata    = (r_state == StIdle) ? dreq.data : cresp.data;
`ifdef UNCACHED_BYPASS_EN
   assign w_bypass   = (dreq.addr[31:29] == 3'b101);
`else
   assign w_bypass   = 1'b0;
`endif
   assign w_hit_ok   = reset_ & (r_state == StIdle) & dreq.valid & w_hit & ~w_bypass;

   always_comb begin
      w_hit     = 1'b0;
      w_hit_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (w_valid[w] && (w_tag[w] == w_req_tag)) begin
            w_hit     = 1'b1;
            w_hit_way = W_W'(w);
         end
      end
   end

   always_comb begin
      for (int w = 0; w < WAYS; w++) begin
         w_set_dirty[w] = w_hit_ok & w_write & (w_hit_way == W_W'(w));
         w_we[w]        = w_set_dirty[w] | (reset_ & (r_state == StFetch) & cresp.ready
                                            & (r_victim == W_W'(w)));
         w_clr_dirty[w] = reset_ & (r_state == StWriteback) & cresp.ready & cresp.last
                          & (r_victim == W_W'(w));
         w_fill[w]      = reset_ & (r_state == StFetch) & cresp.ready & cresp.last
                          & (r_victim == W_W'(w));
      end
   end

   for (genvar g = 0; g < WAYS; g++) begin : g_way
      dcache_way_ram #(
         .SETS       (SETS),
         .LINE_WORDS (LINE_WORDS),
         .IDX_W      (IDX_W),
         .WORD_W     (WORD_W),
         .TAG_W      (TAG_W)
      ) u_ram (
         .clk         (clk),
         .reset_      (reset_),
         .i_index     (w_index),
         .i_word      (w_word_sel),
         .i_we        (w_we[g]),
         .i_strobe    (w_strobe),
         .i_wdata     (w_wdata),
         .i_set_dirty (w_set_dirty[g]),
         .i_clr_dirty (w_clr_dirty[g]),
         .i_fill      (w_fill[g]),
         .i_tag       (w_req_tag),
         .o_word      (w_rd_word[g]),
         .o_tag       (w_tag[g]),
         .o_valid     (w_valid[g]),
         .o_dirty     (w_dirty[g]),
         .o_flat      (w_flat[g])
      );
   end

   always_comb begin
      w_unused = ^{dreq.size, dreq.addr[1:0]};
      for (int w = 0; w < WAYS; w++) begin
         for (int i = 0; i < SETS*LINE_WORDS; i++) begin
            mem[w*SETS*LINE_WORDS+i] = w_flat[w][i*32 +: 32];
            w_unused ^= ^mem[w*SETS*LINE_WORDS+i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_) begin
         r_state  <= StIdle;
         r_beat   <= '0;
         r_victim <= '0;
         for (int s = 0; s < SETS; s++) r_rr[s] <= '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (dreq.valid) begin
`ifdef UNCACHED_BYPASS_EN
                  if (w_bypass) r_state <= StUncached;
                  else
`endif
                  if (!w_hit) begin
                     r_victim <= w_rr_cur;
                     r_state  <= (w_valid[w_rr_cur] && w_dirty[w_rr_cur]) ? StWriteback : StFetch;
                  end
               end
            end
            StWriteback: begin
               if (cresp.ready) begin
                  r_beat <= cresp.last ? '0 : r_beat + 1'b1;
                  if (cresp.last) r_state <= StFetch;
               end
            end
            StFetch: begin
               if (cresp.ready) begin
                  r_beat <= cresp.last ? '0 : r_beat + 1'b1;
                  if (cresp.last) begin
                     r_rr[w_index] <= W_W'((32'(w_rr_cur) + 32'd1) & 32'(WAYS - 1));
                     r_state       <= StIdle;
                  end
               end
            end
`ifdef UNCACHED_BYPASS_EN
            StUncached: begin
               if (cresp.ready && cresp.last) r_state <= StIdle;
            end
`endif
            default: r_state <= StIdle;
         endcase
      end
   end

   always_comb begin
      dresp = '0;
      creq  = '0;
      if (w_hit_ok) begin
         dresp.addr_ok = 1'b1;
         dresp.data_ok = 1'b1;
         dresp.data    = w_rd_word[w_hit_way];
      end
      unique case (r_state)
         StWriteback: begin
            creq.valid    = 1'b1;
            creq.is_write = 1'b1;
            creq.addr     = w_vic_base;
            creq.size     = MSIZE4;
            creq.strobe   = 4'hF;
            creq.data     = w_rd_word[r_victim];
            creq.len      = LINE_LEN;
            creq.burst    = AXI_BURST_INCR;
         end
         StFetch: begin
            creq.valid = 1'b1;
            creq.addr  = w_req_base;
            creq.size  = MSIZE4;
            creq.len   = LINE_LEN;
            creq.burst = AXI_BURST_INCR;
         end
`ifdef UNCACHED_BYPASS_EN
         StUncached: begin
            creq.valid    = 1'b1;
            creq.is_write = w_write;
            creq.addr     = dreq.addr;
            creq.size     = dreq.size;
            creq.strobe   = dreq.strobe;
            creq.data     = dreq.data;
            creq.len      = MLEN1;
            creq.burst    = AXI_BURST_INCR;
            if (reset_ && cresp.ready && cresp.last) begin
               dresp.addr_ok = 1'b1;
               dresp.data_ok = 1'b1;
               dresp.data    = cresp.data;
            end
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: tb/tb_dcache_assoc.sv
// Directed bench for dcache_assoc (WAYS=2, SETS=4, LINE_WORDS=16) with a cbus memory model.
// Covers hits, fills, dirty/clean eviction, reset mid-fetch and the UNCACHED_BYPASS_EN path.
module tb_dcache_assoc;
   import dcache_assoc_pkg::*;

   logic       clk = 1'b0;
   logic       reset_;
   dbus_req_t  dreq;
   dbus_resp_t dresp;
   cbus_req_t  creq;
   cbus_resp_t cresp;

   dcache_assoc #(.WAYS(2), .SETS(4), .LINE_WORDS(16)) u_dut (
      .clk    (clk),
      .reset_ (reset_),
      .dreq   (dreq),
      .dresp  (dresp),
      .creq   (creq),
      .cresp  (cresp)
   );

   always #5 clk = ~clk;

   // ---------------- cbus memory model ----------------
   logic [31:0] mem [1024];
   logic        r_init = 1'b0;
   logic        r_tog  = 1'b0;
   bit          stall_en = 1'b0;
   int          s_beat = 0;
   int          widx;
   int          rd_beats = 0, wr_beats = 0, stab_err = 0, fld_err = 0;
   logic [31:0] rd_addr = '0, wr_addr = '0;
   cbus_req_t   prev_req = '0;
   logic        prev_pend = 1'b0;

   function automatic logic [31:0] init_val(input int i);
      if (i == 16) return 32'hDEADBEEF;
      if (i == 17) return 32'hAAAAAAAA;
      return 32'h1000_0000 + 32'(i);
   endfunction

   always_comb begin
      widx        = ((int'(creq.addr) >>> 2) + s_beat) & 1023;
      cresp       = '0;
      cresp.ready = creq.valid & ~(stall_en & r_tog);
      cresp.last  = (s_beat == int'(creq.len));
      cresp.data  = mem[widx];
   end

   always @(posedge clk) begin
      r_tog <= ~r_tog;
      if (!r_init) begin
         for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
         r_init <= 1'b1;
      end
      if (reset_ && prev_pend && (creq != prev_req)) stab_err <= stab_err + 1;
      prev_req  <= creq;
      prev_pend <= reset_ & creq.valid & ~cresp.ready;
      if (reset_ && creq.valid) begin
         if (creq.addr[31:29] == 3'b101) begin
            if (creq.len != MLEN1) fld_err <= fld_err + 1;
         end else if (creq.size != MSIZE4 || creq.len != MLEN16 || creq.burst != AXI_BURST_INCR
                      || creq.strobe != (creq.is_write ? 4'hF : 4'h0) || creq.addr[5:0] != 6'd0) begin
            fld_err <= fld_err + 1;
         end
      end
      if (!reset_) begin
         s_beat <= 0;
      end else if (cresp.ready) begin
         if (creq.is_write) begin
            for (int b = 0; b < 4; b++)
               if (creq.strobe[b]) mem[widx][8*b +: 8] <= creq.data[8*b +: 8];
            wr_beats <= wr_beats + 1;
            if (s_beat == 0) wr_addr <= creq.addr;
         end else begin
            rd_beats <= rd_beats + 1;
            if (s_beat == 0) rd_addr <= creq.addr;
         end
         s_beat <= cresp.last ? 0 : s_beat + 1;
      end
   end

   // ---------------- checking ----------------
   int n_vec = 0, n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h want %08h", name, act, exp);
      end
   endtask

   task automatic do_req(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wd,
                         output logic [31:0] rdata, output int cyc, output bit ok,
                         output int rdb, output int wrb);
      int rd0, wr0;
      rd0 = rd_beats;
      wr0 = wr_beats;
      @(negedge clk);
      dreq.valid  = 1'b1;
      dreq.addr   = addr;
      dreq.size   = MSIZE4;
      dreq.strobe = strb;
      dreq.data   = wd;
      cyc   = 0;
      ok    = 1'b0;
      rdata = '0;
      while (!ok && cyc < 400) begin
         #1;
         if (dresp.data_ok) begin
            ok    = 1'b1;
            rdata = dresp.data;
         end else begin
            @(negedge clk);
            cyc++;
         end
      end
      @(posedge clk);
      #1;
      dreq.valid = 1'b0;
      rdb = rd_beats - rd0;
      wrb = wr_beats - wr0;
   endtask

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  strb;
      logic [31:0] wdata;
      logic [31:0] exp_data;
      int          exp_rd;
      int          exp_wr;
      logic [31:0] exp_rd_addr;
      logic [31:0] exp_wr_addr;
      int          exp_cyc;
      bit          stall;
   } vec_t;

   function automatic vec_t mk(input logic [31:0] a, input logic [3:0] s, input logic [31:0] wd,
                               input logic [31:0] ed, input int er, input int ew,
                               input logic [31:0] era, input logic [31:0] ewa,
                               input int ec, input bit st);
      vec_t v;
      v.addr = a; v.strb = s; v.wdata = wd; v.exp_data = ed; v.exp_rd = er; v.exp_wr = ew;
      v.exp_rd_addr = era; v.exp_wr_addr = ewa; v.exp_cyc = ec; v.stall = st;
      return v;
   endfunction

   task automatic run_vec(input string tag, input vec_t v);
      logic [31:0] rd;
      int          cyc, rdb, wrb;
      bit          ok;
      stall_en = v.stall;
      do_req(v.addr, v.strb, v.wdata, rd, cyc, ok, rdb, wrb);
      chk({tag, " data_ok"}, 32'(ok), 32'd1);
      if (v.strb == 4'h0) chk({tag, " rdata"}, rd, v.exp_data);
      chk({tag, " rd_beats"}, 32'(rdb), 32'(v.exp_rd));
      chk({tag, " wr_beats"}, 32'(wrb), 32'(v.exp_wr));
      if (v.exp_rd > 0) chk({tag, " rd_addr"}, rd_addr, v.exp_rd_addr);
      if (v.exp_wr > 0) chk({tag, " wr_addr"}, wr_addr, v.exp_wr_addr);
      if (v.exp_cyc >= 0) chk({tag, " latency"}, 32'(cyc), 32'(v.exp_cyc));
   endtask

   vec_t vecs[12];

   initial begin : main
      int k;
      vecs[0]  = mk(32'h040, 4'h0, 32'h0,        32'hDEADBEEF, 16, 0,  32'h040, 32'h0, 17, 1'b0);
      vecs[1]  = mk(32'h040, 4'h0, 32'h0,        32'hDEADBEEF, 0,  0,  32'h0,   32'h0, 0,  1'b1);
      vecs[2]  = mk(32'h044, 4'h3, 32'h12345678, 32'h0,        0,  0,  32'h0,   32'h0, 0,  1'b1);
      vecs[3]  = mk(32'h044, 4'h0, 32'h0,        32'hAAAA5678, 0,  0,  32'h0,   32'h0, 0,  1'b1);
      vecs[4]  = mk(32'h000, 4'hF, 32'hCAFEF00D, 32'h0,        16, 0,  32'h000, 32'h0, -1, 1'b1);
      vecs[5]  = mk(32'h104, 4'h0, 32'h0,        32'h10000041, 16, 0,  32'h100, 32'h0, -1, 1'b1);
      vecs[6]  = mk(32'h208, 4'h0, 32'h0,        32'h10000082, 16, 16, 32'h200, 32'h0, 33, 1'b0);
      vecs[7]  = mk(32'h000, 4'h0, 32'h0,        32'hCAFEF00D, 16, 0,  32'h000, 32'h0, -1, 1'b1);
      vecs[8]  = mk(32'h100, 4'h0, 32'h0,        32'h10000040, 16, 0,  32'h100, 32'h0, -1, 1'b1);
      vecs[9]  = mk(32'h004, 4'h0, 32'h0,        32'h10000001, 0,  0,  32'h0,   32'h0, 0,  1'b1);
      vecs[10] = mk(32'h13C, 4'h0, 32'h0,        32'h1000004F, 0,  0,  32'h0,   32'h0, 0,  1'b1);
      vecs[11] = mk(32'h044, 4'h0, 32'h0,        32'hAAAA5678, 0,  0,  32'h0,   32'h0, 0,  1'b1);

      dreq   = '0;
      reset_ = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset outputs", {31'd0, creq.valid} | {30'd0, dresp.addr_ok, dresp.data_ok}
                           | dresp.data, 32'd0);
      reset_ = 1'b1;

      for (int i = 0; i < 12; i++) run_vec($sformatf("v%0d", i), vecs[i]);
      chk("mem[0] after writeback", mem[0], 32'hCAFEF00D);

      // Reset during FETCH beat 5 abandons the burst and the fill.
      begin
         int rd0;
         stall_en = 1'b0;
         rd0 = rd_beats;
         @(negedge clk);
         dreq.valid  = 1'b1;
         dreq.addr   = 32'h300;
         dreq.strobe = 4'h0;
         k = 0;
         while ((rd_beats - rd0) != 5 && k < 100) begin
            @(negedge clk);
            k++;
         end
         chk("reach beat 5", 32'(rd_beats - rd0), 32'd5);
         reset_     = 1'b0;
         dreq.valid = 1'b0;
         @(posedge clk);
         #1;
         chk("creq.valid after reset", 32'(creq.valid), 32'd0);
         @(negedge clk);
         reset_ = 1'b1;
      end
      run_vec("rst_refetch", mk(32'h300, 4'h0, 32'h0, 32'h100000C0, 16, 0, 32'h300, 32'h0, 17, 1'b0));
      run_vec("rst_dirty_lost", mk(32'h044, 4'h0, 32'h0, 32'hAAAAAAAA, 16, 0, 32'h040, 32'h0, -1,
                                   1'b1));

`ifdef UNCACHED_BYPASS_EN
      run_vec("unc_write", mk(32'hA000_0010, 4'hF, 32'h55AA33CC, 32'h0, 0, 1, 32'h0, 32'hA000_0010,
                              1, 1'b0));
      run_vec("unc_read", mk(32'hA000_0010, 4'h0, 32'h0, 32'h55AA33CC, 1, 0, 32'hA000_0010, 32'h0,
                             1, 1'b0));
      run_vec("alias_miss", mk(32'h010, 4'h0, 32'h0, 32'h55AA33CC, 16, 0, 32'h000, 32'h0, -1, 1'b1));
      run_vec("unc_no_disturb", mk(32'h300, 4'h0, 32'h0, 32'h100000C0, 0, 0, 32'h0, 32'h0, 0, 1'b1));
`endif

      chk("creq stable while stalled", 32'(stab_err), 32'd0);
      chk("creq field encoding", 32'(fld_err), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

endmodule
